cw310_usb_host_master: RTL and testbench

- Host-side initiator for the CW310 parallel USB register bus; the counterpart of the target-side USB register frontend.
- Converts command/stream transactions into usb_addr/usb_din/usb_cen/usb_rdn/usb_wrn byte cycles.
- Samples read data from usb_dout and checks usb_isout.
- Used in NTT-top simulation benches and on-FPGA loopback to drive the register frontend exactly as the SAM3U host does.

---
 rtl/cw310_usb_pkg.sv | 18 +
 rtl/cw310_usb_host_master.sv | 160 ++++++++++++++++
 tb/tb_cw310_usb_host_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cw310_usb_pkg.sv
// rtl/cw310_usb_pkg.sv - shared types, widths and timing for the CW310 USB register bus
package cw310_usb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_e;

  localparam int ADDR_WIDTH    = 21;
  localparam int BYTECNT_SIZE  = 7;
  localparam int RD_STROBE     = 4;
  localparam int RD_SAMPLE_DLY = 3;

  // Bumps only the byte-count field; register-select bits above it are preserved.
  function automatic logic [31:0] addr_inc(input logic [31:0] addr, input int unsigned bc_size);
    logic [31:0] mask;
    mask = (32'd1 << bc_size) - 32'd1;
    return (addr & ~mask) | ((addr + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/cw310_usb_host_master.sv
// rtl/cw310_usb_host_master.sv - host-side byte-cycle initiator for the CW310 USB register bus
module cw310_usb_host_master
  import cw310_usb_pkg::*;
#(
  parameter int pADDR_WIDTH    = ADDR_WIDTH,
  parameter int pBYTECNT_SIZE  = BYTECNT_SIZE,
  parameter int pRD_STROBE     = RD_STROBE,
  parameter int pRD_SAMPLE_DLY = RD_SAMPLE_DLY,
  parameter int pGAP           = 1
) (
  input  logic                     usb_clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [pADDR_WIDTH-1:0]   cmd_addr,
  input  logic [pBYTECNT_SIZE:0]   cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_data,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     done,
  output logic                     err_isout,
  output logic [pADDR_WIDTH-1:0]   usb_addr,
  output logic [7:0]               usb_din,
  input  logic [7:0]               usb_dout,
  input  logic                     usb_isout,
  output logic                     usb_rdn,
  output logic                     usb_wrn,
  output logic                     usb_cen,
  output logic                     usb_alen
);

  localparam int LEN_W = pBYTECNT_SIZE + 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(pRD_SAMPLE_DLY);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(pRD_STROBE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(pGAP - 1);

  state_e                   state_q, state_d;
  logic                     write_q, write_d;
  logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]         remain_q, remain_d;
  logic [7:0]               din_q, din_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     strobe;

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      remain_q   <= '0;
      din_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    strobe     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d  = cmd_write;
          addr_d   = cmd_addr;
          remain_d = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          err_d    = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d = '0;
        if (write_q) begin
          wr_ready = wr_valid;
          if (wr_valid) begin
            din_d   = wr_data;
            state_d = STROBE;
          end
        end else begin
          state_d = STROBE;
        end
      end
      STROBE: begin
        strobe = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (!write_q && cnt_q == SAMPLE_AT) begin
          rd_data_d  = usb_dout;
          rd_valid_d = 1'b1;
          if (!usb_isout) err_d = 1'b1;
        end
        // The target latches a write on every low cycle, so writes strobe exactly once.
        if (write_q || cnt_q == RD_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d    = '0;
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = pADDR_WIDTH'(addr_inc(32'(addr_q), pBYTECNT_SIZE));
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state flop so an async reset releases them at once.
  assign usb_cen   = ~strobe;
  assign usb_wrn   = ~(strobe & write_q);
  assign usb_rdn   = ~(strobe & ~write_q);
  assign usb_alen  = 1'b1;
  assign usb_addr  = addr_q;
  assign usb_din   = din_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err_isout = err_q;

endmodule

// File: tb/tb_cw310_usb_host_master.sv
// tb/tb_cw310_usb_host_master.sv - self-checking bench for cw310_usb_host_master
module tb_cw310_usb_host_master;

  localparam int P_GAP       = 1;
  localparam int P_RD_STROBE = 4;

  logic        usb_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [20:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [7:0]  wr_data = '0;
  logic        rd_valid, done, err_isout;
  logic [7:0]  rd_data;
  logic [20:0] usb_addr;
  logic [7:0]  usb_din, usb_dout;
  logic        usb_isout, usb_rdn, usb_wrn, usb_cen, usb_alen;
  logic        isout_force_low = 1'b0;

  always #5 usb_clk = ~usb_clk;

  // Target: returns 0x10 + byte-count field, drives the bus whenever read-strobed.
  assign usb_dout  = 8'h10 + {1'b0, usb_addr[6:0]};
  assign usb_isout = isout_force_low ? 1'b0 : ~usb_rdn;

  cw310_usb_host_master dut (
    .usb_clk(usb_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err_isout(err_isout),
    .usb_addr(usb_addr), .usb_din(usb_din), .usb_dout(usb_dout), .usb_isout(usb_isout),
    .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen), .usb_alen(usb_alen)
  );

  int total = 0, passed = 0, fails = 0;
  int cyc = 0;
  always @(posedge usb_clk) cyc <= cyc + 1;

  logic [28:0] wlog[$];
  logic [7:0]  rlog[$];
  int          runs[$];
  logic [20:0] aseq[$];
  int          done_cnt = 0, unstable = 0, run = 0;
  logic        prev_low = 1'b0;
  logic [20:0] prev_addr = '0;
  logic [7:0]  prev_din = '0;

  always @(negedge usb_clk) begin
    if (!rst_n) begin
      run = 0;
      prev_low = 1'b0;
    end else begin
      if (!usb_cen && !usb_wrn) wlog.push_back({usb_addr, usb_din});
      if (rd_valid) rlog.push_back(rd_data);
      if (done) done_cnt++;
      if (!usb_rdn) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (!usb_cen) begin
        if (!prev_low) aseq.push_back(usb_addr);
        else if (usb_addr !== prev_addr || usb_din !== prev_din) unstable++;
      end
      prev_low  = ~usb_cen;
      prev_addr = usb_addr;
      prev_din  = usb_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] exp_addr(input logic [20:0] a, input int i);
    return {a[20:7], 7'((int'(a[6:0]) + i) % 128)};
  endfunction

  task automatic run_burst(input logic w, input logic [20:0] a, input logic [7:0] len,
                           input logic [7:0] d0, input int stall_idx, input int stall_cyc,
                           input string tag);
    logic [7:0] data[$];
    int n, acc, lat, extra, bad, c, dc0;
    bit got;
    n = (len == 8'd0) ? 1 : int'(len);
    for (int i = 0; i < n; i++)
      data.push_back((d0 == 8'h00) ? 8'($urandom_range(0, 255)) : 8'(d0 + 8'(i * 17)));
    wlog.delete(); rlog.delete(); runs.delete(); aseq.delete();
    dc0 = done_cnt;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len;
    @(posedge usb_clk); #1;
    acc = cyc;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 21'($urandom); cmd_len = 8'($urandom);
    extra = 0; bad = 0;
    if (w) begin
      for (int i = 0; i < n; i++) begin
        if (i == stall_idx) begin
          wr_valid = 1'b0;
          for (int j = 0; j < stall_cyc; j++) begin
            @(negedge usb_clk);
            if ((i == 0 || j >= 1) && (usb_cen !== 1'b1 || usb_wrn !== 1'b1)) bad++;
            if ((i == 0 || j >= 1 + P_GAP) && usb_addr !== exp_addr(a, i)) bad++;
            @(posedge usb_clk); #1;
          end
          extra = (i == 0) ? stall_cyc :
                  ((stall_cyc > 1 + P_GAP) ? stall_cyc - (1 + P_GAP) : 0);
        end
        wr_valid = 1'b1; wr_data = data[i]; got = 0; c = 0;
        while (!got && c < 50) begin
          @(negedge usb_clk);
          if (wr_ready === 1'b1) got = 1;
          @(posedge usb_clk); #1;
          c++;
        end
        wr_valid = 1'b0;
        if (!got) check({tag, " wr_accept"}, 32'(got), 32'd1);
      end
      if (stall_cyc > 0) check({tag, " stall_hold"}, 32'(bad), 32'd0);
    end
    got = 0; c = 0;
    while (!got && c < 400) begin
      @(negedge usb_clk);
      if (done === 1'b1) got = 1;
      c++;
    end
    lat = cyc - acc;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " cmd_ready_at_done"}, 32'(cmd_ready), 32'd1);
    check({tag, " latency"}, 32'(lat),
          32'(w ? n * (2 + P_GAP) + extra : n * (1 + P_RD_STROBE + P_GAP)));
    @(negedge usb_clk); #1;
    check({tag, " done_pulse_once"}, 32'(done_cnt - dc0), 32'd1);
    check({tag, " done_low_after"}, 32'(done), 32'd0);
    if (w) begin
      check({tag, " write_count"}, 32'(wlog.size()), 32'(n));
      for (int i = 0; i < n && i < wlog.size(); i++)
        check($sformatf("%s write%0d", tag, i), 32'(wlog[i]), 32'({exp_addr(a, i), data[i]}));
    end else begin
      check({tag, " read_count"}, 32'(rlog.size()), 32'(n));
      for (int i = 0; i < n && i < rlog.size(); i++)
        check($sformatf("%s read%0d", tag, i), 32'(rlog[i]),
              32'(8'(16 + ((int'(a[6:0]) + i) % 128))));
      check({tag, " rd_strobe_count"}, 32'(runs.size()), 32'(n));
      for (int i = 0; i < n && i < runs.size(); i++)
        check($sformatf("%s rdn_low%0d", tag, i), 32'(runs[i]), 32'(P_RD_STROBE));
    end
    check({tag, " addr_data_stable"}, 32'(unstable), 32'd0);
  endtask

  initial begin
    int dc_before, c;
    repeat (3) @(negedge usb_clk);
    #1;
    check("rst usb_cen", 32'(usb_cen), 32'd1);
    check("rst usb_rdn", 32'(usb_rdn), 32'd1);
    check("rst usb_wrn", 32'(usb_wrn), 32'd1);
    check("rst usb_addr", 32'(usb_addr), 32'd0);
    check("rst usb_din", 32'(usb_din), 32'd0);
    check("rst rd_data", 32'(rd_data), 32'd0);
    check("rst pulses", 32'({rd_valid, done, wr_ready, err_isout}), 32'd0);
    @(negedge usb_clk);
    rst_n = 1'b1;
    @(negedge usb_clk); #1;
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("usb_alen", 32'(usb_alen), 32'd1);

    run_burst(1'b1, 21'h000100, 8'd4, 8'hA1, -1, 0, "wr4");
    run_burst(1'b0, 21'h000280, 8'd3, 8'h00, -1, 0, "rd3");
    check("rd3 err_isout", 32'(err_isout), 32'd0);
    run_burst(1'b1, 21'h00017E, 8'd4, 8'h00, -1, 0, "wrap");
    check("wrap addr2", (aseq.size() == 4) ? 32'(aseq[2]) : 32'hFFFF_FFFF, 32'h100);
    check("wrap addr3", (aseq.size() == 4) ? 32'(aseq[3]) : 32'hFFFF_FFFF, 32'h101);
    run_burst(1'b1, 21'h0A5540, 8'd3, 8'h30, 1, 5, "stall");

    isout_force_low = 1'b1;
    run_burst(1'b0, 21'h001F00, 8'd2, 8'h00, -1, 0, "isout");
    check("isout err sticky", 32'(err_isout), 32'd1);
    isout_force_low = 1'b0;
    run_burst(1'b1, 21'h001F00, 8'd1, 8'h77, -1, 0, "isout_clr");
    check("isout err cleared", 32'(err_isout), 32'd0);

    for (int k = 0; k < 6; k++) begin
      logic w;
      logic [7:0] len;
      w = 1'($urandom_range(0, 1));
      len = 8'($urandom_range(0, 5));
      run_burst(w, 21'($urandom), len, 8'h00,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                $sformatf("rand%0d", k));
    end

    dc_before = done_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 21'h0002A5; cmd_len = 8'd4;
    @(posedge usb_clk); #1;
    cmd_valid = 1'b0;
    c = 0;
    while (usb_rdn !== 1'b0 && c < 50) begin
      @(negedge usb_clk);
      c++;
    end
    check("midrst strobe reached", 32'(usb_rdn), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst usb_rdn", 32'(usb_rdn), 32'd1);
    check("midrst usb_cen", 32'(usb_cen), 32'd1);
    repeat (3) @(negedge usb_clk);
    rst_n = 1'b1;
    @(negedge usb_clk); #1;
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst addr", 32'(usb_addr), 32'd0);
    check("midrst rd_data", 32'(rd_data), 32'd0);
    repeat (8) @(negedge usb_clk);
    #1;
    check("midrst no done", 32'(done_cnt - dc_before), 32'd0);
    check("midrst idle strobes", 32'({usb_cen, usb_rdn, usb_wrn}), 32'd7);
    run_burst(1'b0, 21'h000033, 8'd0, 8'h00, -1, 0, "len0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
